// File: rtl/add_share_arbiter_if.sv
// Handshake bundle between the two adder requesters, the result consumer and add_share_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface add_share_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_op0;
  logic [WIDTH-1:0] a_op1;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_op0;
  logic [WIDTH-1:0] b_op1;
  logic             b_ready;
  logic             res_valid;
  logic [WIDTH:0]   res_sum;
  logic             res_src;
  logic             res_ready;
  logic [7:0]       op_count;

  modport slave (
    input  a_valid, a_op0, a_op1, b_valid, b_op0, b_op1, res_ready,
    output a_ready, b_ready, res_valid, res_sum, res_src, op_count
  );

  modport master (
    output a_valid, a_op0, a_op1, b_valid, b_op0, b_op1, res_ready,
    input  a_ready, b_ready, res_valid, res_sum, res_src, op_count
  );
endinterface

// File: rtl/add_share_arbiter.sv
// Round-robin sharing of one adder between requesters A and B, with a
// single-entry result stage that holds under backpressure and a synchronous flush.
module add_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  add_share_arbiter_if.slave   bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic             prio;
  logic             can_accept;
  logic             grant_a;
  logic             grant_b;
  logic             accept;
  logic [WIDTH:0]   sum_a;
  logic [WIDTH:0]   sum_b;
  logic [WIDTH:0]   res_sum_q;
  logic             res_src_q;
  logic [7:0]       op_count_q;

  // rst_n is folded in so neither ready can rise while reset is held.
  assign can_accept = rst_n & ~flush & ((state == EMPTY) | bus.res_ready);

  assign grant_a = bus.a_valid & (~bus.b_valid | ~prio);
  assign grant_b = bus.b_valid & (~bus.a_valid |  prio);

  assign bus.a_ready = can_accept & grant_a;
  assign bus.b_ready = can_accept & grant_b;
  assign accept      = bus.a_ready | bus.b_ready;

  assign sum_a = {1'b0, bus.a_op0} + {1'b0, bus.a_op1};
  assign sum_b = {1'b0, bus.b_op0} + {1'b0, bus.b_op1};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      prio       <= 1'b0;
      res_sum_q  <= '0;
      res_src_q  <= 1'b0;
      op_count_q <= '0;
    end else if (flush) begin
      // Result payload and delivery count survive a flush; only occupancy and history clear.
      state <= EMPTY;
      prio  <= 1'b0;
    end else begin
      if ((state == FULL) && bus.res_ready) begin
        op_count_q <= op_count_q + 8'd1;
      end
      if (accept) begin
        state     <= FULL;
        prio      <= bus.a_ready;
        res_sum_q <= bus.a_ready ? sum_a : sum_b;
        res_src_q <= bus.b_ready;
      end else if (bus.res_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.res_valid = (state == FULL);
  assign bus.res_sum   = res_sum_q;
  assign bus.res_src   = res_src_q;
  assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed self-checking bench for add_share_arbiter: reset, single grants,
// carry, contention, backpressure, flush, mid-run reset and op_count wrap.
module tb_add_share_arbiter;

  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_pass;
  int   n_total;

  add_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  add_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] o0, input logic [7:0] o1);
    bus.a_valid = v;
    bus.a_op0   = o0;
    bus.a_op1   = o1;
  endtask

  task automatic drive_b(input logic v, input logic [7:0] o0, input logic [7:0] o1);
    bus.b_valid = v;
    bus.b_op0   = o0;
    bus.b_op1   = o1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    bus.res_ready = 1'b0;
    drive_a(1'b1, 8'h11, 8'h22);
    drive_b(1'b1, 8'h33, 8'h44);
    #12;
    n_total++;
    if ({bus.a_ready, bus.b_ready} !== 2'b00) $display("FAIL reset_readies got=%b exp=00", {bus.a_ready, bus.b_ready});
    else n_pass++;
    n_total++;
    if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid);
    else n_pass++;
    n_total++;
    if (bus.res_sum !== 9'h000) $display("FAIL reset_res_sum got=%h exp=000", bus.res_sum);
    else n_pass++;
    n_total++;
    if (bus.op_count !== 8'd0) $display("FAIL reset_op_count got=%0d exp=0", bus.op_count);
    else n_pass++;
    drive_a(1'b0, 8'h00, 8'h00);
    drive_b(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_a();
    bus.res_ready = 1'b1;
    drive_a(1'b1, 8'h7F, 8'h01);
    #1;
    n_total++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) $display("FAIL single_a_ready got=%b exp=10", {bus.a_ready, bus.b_ready});
    else n_pass++;
    tick();
    drive_a(1'b0, 8'h00, 8'h00);
    #1;
    n_total++;
    if ({bus.res_valid, bus.res_sum, bus.res_src} !== {1'b1, 9'h080, 1'b0})
      $display("FAIL single_a_result got=v%b s%h src%b exp=v1 s080 src0", bus.res_valid, bus.res_sum, bus.res_src);
    else n_pass++;
    n_total++;
    if (bus.op_count !== 8'd0) $display("FAIL single_a_count_early got=%0d exp=0", bus.op_count);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.res_valid, bus.op_count} !== {1'b0, 8'd1})
      $display("FAIL single_a_delivered got=v%b c%0d exp=v0 c1", bus.res_valid, bus.op_count);
    else n_pass++;
  endtask

  task automatic test_carry();
    drive_b(1'b1, 8'hFF, 8'hFF);
    #1;
    n_total++;
    if ({bus.a_ready, bus.b_ready} !== 2'b01) $display("FAIL carry_ready got=%b exp=01", {bus.a_ready, bus.b_ready});
    else n_pass++;
    tick();
    drive_b(1'b0, 8'h00, 8'h00);
    #1;
    n_total++;
    if ({bus.res_valid, bus.res_sum, bus.res_src} !== {1'b1, 9'h1FE, 1'b1})
      $display("FAIL carry_result got=v%b s%h src%b exp=v1 s1FE src1", bus.res_valid, bus.res_sum, bus.res_src);
    else n_pass++;
    tick();
    n_total++;
    if (bus.op_count !== 8'd2) $display("FAIL carry_count got=%0d exp=2", bus.op_count);
    else n_pass++;
  endtask

  // A gives 0x10+0x20=0x030, B gives 0x40+0x50=0x090; prio is 0 on entry.
  task automatic test_contention();
    logic       exp_src;
    logic [8:0] exp_sum;
    drive_a(1'b1, 8'h10, 8'h20);
    drive_b(1'b1, 8'h40, 8'h50);
    for (int i = 0; i < 4; i++) begin
      exp_src = (i % 2 == 1);
      exp_sum = exp_src ? 9'h090 : 9'h030;
      #1;
      n_total++;
      if ({bus.a_ready, bus.b_ready} !== {~exp_src, exp_src})
        $display("FAIL contention_grant%0d got=%b exp=%b", i, {bus.a_ready, bus.b_ready}, {~exp_src, exp_src});
      else n_pass++;
      tick();
      n_total++;
      if ({bus.res_valid, bus.res_src, bus.res_sum} !== {1'b1, exp_src, exp_sum})
        $display("FAIL contention_result%0d got=v%b src%b s%h exp=v1 src%b s%h",
                 i, bus.res_valid, bus.res_src, bus.res_sum, exp_src, exp_sum);
      else n_pass++;
    end
    drive_a(1'b0, 8'h00, 8'h00);
    drive_b(1'b0, 8'h00, 8'h00);
    tick();
    n_total++;
    if ({bus.res_valid, bus.op_count} !== {1'b0, 8'd6})
      $display("FAIL contention_count got=v%b c%0d exp=v0 c6", bus.res_valid, bus.op_count);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    drive_a(1'b1, 8'h01, 8'h02);
    tick();
    drive_a(1'b0, 8'h00, 8'h00);
    drive_b(1'b1, 8'h03, 8'h04);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if ({bus.a_ready, bus.b_ready, bus.res_valid, bus.res_sum, bus.res_src} !== {2'b00, 1'b1, 9'h003, 1'b0})
        $display("FAIL backpressure_hold%0d got=rdy%b v%b s%h src%b exp=rdy00 v1 s003 src0",
                 i, {bus.a_ready, bus.b_ready}, bus.res_valid, bus.res_sum, bus.res_src);
      else n_pass++;
      tick();
    end
    bus.res_ready = 1'b1;
    #1;
    n_total++;
    if ({bus.a_ready, bus.b_ready} !== 2'b01) $display("FAIL backpressure_release got=%b exp=01", {bus.a_ready, bus.b_ready});
    else n_pass++;
    tick();
    drive_b(1'b0, 8'h00, 8'h00);
    n_total++;
    if ({bus.res_valid, bus.res_sum, bus.res_src, bus.op_count} !== {1'b1, 9'h007, 1'b1, 8'd7})
      $display("FAIL backpressure_new got=v%b s%h src%b c%0d exp=v1 s007 src1 c7",
               bus.res_valid, bus.res_sum, bus.res_src, bus.op_count);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.res_valid, bus.op_count} !== {1'b0, 8'd8})
      $display("FAIL backpressure_drain got=v%b c%0d exp=v0 c8", bus.res_valid, bus.op_count);
    else n_pass++;
  endtask

  task automatic test_flush();
    bus.res_ready = 1'b0;
    drive_a(1'b1, 8'h05, 8'h06);
    tick();
    drive_b(1'b1, 8'h07, 8'h08);
    bus.res_ready = 1'b1;
    flush = 1'b1;
    #1;
    n_total++;
    if ({bus.a_ready, bus.b_ready} !== 2'b00) $display("FAIL flush_readies got=%b exp=00", {bus.a_ready, bus.b_ready});
    else n_pass++;
    tick();
    flush = 1'b0;
    #1;
    n_total++;
    if ({bus.res_valid, bus.op_count, bus.res_sum, bus.res_src} !== {1'b0, 8'd8, 9'h00B, 1'b0})
      $display("FAIL flush_state got=v%b c%0d s%h src%b exp=v0 c8 s00B src0",
               bus.res_valid, bus.op_count, bus.res_sum, bus.res_src);
    else n_pass++;
    n_total++;
    if ({bus.a_ready, bus.b_ready} !== 2'b10) $display("FAIL flush_prio_cleared got=%b exp=10", {bus.a_ready, bus.b_ready});
    else n_pass++;
    tick();
    drive_a(1'b0, 8'h00, 8'h00);
    drive_b(1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b0;
    drive_a(1'b1, 8'h20, 8'h22);
    drive_b(1'b1, 8'h30, 8'h33);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.res_valid, bus.res_sum, bus.res_src, bus.op_count} !== {1'b0, 9'h000, 1'b0, 8'd0})
      $display("FAIL reset_mid_state got=v%b s%h src%b c%0d exp=v0 s000 src0 c0",
               bus.res_valid, bus.res_sum, bus.res_src, bus.op_count);
    else n_pass++;
    bus.res_ready = 1'b1;
    #1;
    n_total++;
    if ({bus.a_ready, bus.b_ready} !== 2'b00) $display("FAIL reset_mid_readies got=%b exp=00", {bus.a_ready, bus.b_ready});
    else n_pass++;
    drive_a(1'b0, 8'h00, 8'h00);
    drive_b(1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // 256 accepting edges deliver 255 results; the drain edge wraps the count to 0.
  task automatic test_count_wrap();
    bus.res_ready = 1'b1;
    drive_a(1'b1, 8'h01, 8'h01);
    for (int i = 0; i < 256; i++) tick();
    drive_a(1'b0, 8'h00, 8'h00);
    n_total++;
    if (bus.op_count !== 8'd255) $display("FAIL wrap_before got=%0d exp=255", bus.op_count);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.res_valid, bus.op_count} !== {1'b0, 8'd0})
      $display("FAIL wrap_after got=v%b c%0d exp=v0 c0", bus.res_valid, bus.op_count);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single_a();
    test_carry();
    test_contention();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_count_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
